// File: rtl/m_xnor_prbs_chk.sv
// Receive-side checker for the XNOR PRBS-15 stream (x^15 + x^14 + 1).
// It seeds from 15 received bits, verifies LOCK_CNT predictions, then
// counts mismatches (saturating) while locked. Too many consecutive
// misses drop it back to seeding.
module m_xnor_prbs_chk #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_THR = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             din_vld,
   input  logic             din,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             lockup
);

   typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

   localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
   localparam logic [7:0]       LOSS_C  = 8'(LOSS_THR);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t           state_reg, state_next;
   logic [14:0]      sr_reg, sr_next;
   logic [3:0]       seed_cnt_reg, seed_cnt_next;
   logic [7:0]       match_cnt_reg, match_cnt_next;
   logic [7:0]       miss_cnt_reg, miss_cnt_next;
   logic             locked_reg, locked_next;
   logic             err_reg, err_next;
   logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
   logic             lockup_reg, lockup_next;

   logic             pred;
   logic [14:0]      sr_shift;

   assign pred     = ~(sr_reg[14] ^ sr_reg[13]);
   assign sr_shift = {sr_reg[13:0], din};

   // Next-state logic: seeding, verification and locked error counting.
   always_comb begin
      state_next     = state_reg;
      sr_next        = sr_reg;
      seed_cnt_next  = seed_cnt_reg;
      match_cnt_next = match_cnt_reg;
      miss_cnt_next  = miss_cnt_reg;
      err_next       = 1'b0;
      err_cnt_next   = err_cnt_reg;
      lockup_next    = lockup_reg;

      if (clr) begin
         state_next     = SEED;
         sr_next        = '0;
         seed_cnt_next  = '0;
         match_cnt_next = '0;
         miss_cnt_next  = '0;
         err_cnt_next   = '0;
         lockup_next    = 1'b0;
      end else if (din_vld) begin
         unique case (state_reg)
            SEED: begin
               sr_next = sr_shift;
               if (seed_cnt_reg == 4'd14) begin
                  // 15th bit: the register now holds a full candidate seed.
                  seed_cnt_next = '0;
                  if (&sr_shift) begin
                     lockup_next = 1'b1;
                  end else begin
                     lockup_next    = 1'b0;
                     state_next     = VERIFY;
                     match_cnt_next = '0;
                  end
               end else begin
                  seed_cnt_next = seed_cnt_reg + 4'd1;
               end
            end
            VERIFY: begin
               sr_next = sr_shift;
               if (din == pred) begin
                  if (match_cnt_reg + 8'd1 == LOCK_C) begin
                     state_next    = LOCKED;
                     miss_cnt_next = '0;
                  end else begin
                     match_cnt_next = match_cnt_reg + 8'd1;
                  end
               end else begin
                  state_next    = SEED;
                  seed_cnt_next = '0;
               end
            end
            LOCKED: begin
               // Advance on the prediction so a flipped bit is not
               // fed back into the register and counted again.
               sr_next = {sr_reg[13:0], pred};
               if (din != pred) begin
                  err_next = 1'b1;
                  if (err_cnt_reg != ERR_MAX)
                     err_cnt_next = err_cnt_reg + 1'b1;
                  if (miss_cnt_reg + 8'd1 == LOSS_C) begin
                     state_next    = SEED;
                     seed_cnt_next = '0;
                     miss_cnt_next = '0;
                  end else begin
                     miss_cnt_next = miss_cnt_reg + 8'd1;
                  end
               end else begin
                  miss_cnt_next = '0;
               end
            end
            default: state_next = SEED;
         endcase
      end

      locked_next = (state_next == LOCKED);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SEED;
         sr_reg        <= '0;
         seed_cnt_reg  <= '0;
         match_cnt_reg <= '0;
         miss_cnt_reg  <= '0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
         err_cnt_reg   <= '0;
         lockup_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sr_reg        <= sr_next;
         seed_cnt_reg  <= seed_cnt_next;
         match_cnt_reg <= match_cnt_next;
         miss_cnt_reg  <= miss_cnt_next;
         locked_reg    <= locked_next;
         err_reg       <= err_next;
         err_cnt_reg   <= err_cnt_next;
         lockup_reg    <= lockup_next;
      end
   end

   assign locked  = locked_reg;
   assign err     = err_reg;
   assign err_cnt = err_cnt_reg;
   assign lockup  = lockup_reg;

endmodule

// File: tb/tb_m_xnor_prbs_chk.sv
// Directed bench for m_xnor_prbs_chk: lock, single error, loss/relock,
// gapped input, lockup stream, saturation with clear, and async reset.
module tb_m_xnor_prbs_chk;

   logic        clk = 1'b0;
   logic        rst_n, clr, din_vld, din;
   logic        locked, err, lockup;
   logic [15:0] err_cnt;
   logic        s_locked, s_err, s_lockup;
   logic [3:0]  s_err_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [14:0] g;
   int          err_pulses;
   int          nv, cyc;

   always #5 clk = ~clk;

   m_xnor_prbs_chk u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld), .din(din),
      .locked(locked), .err(err), .err_cnt(err_cnt), .lockup(lockup)
   );

   m_xnor_prbs_chk #(.LOCK_CNT(8), .LOSS_THR(255), .ERR_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld), .din(din),
      .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt), .lockup(s_lockup)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle and sample 1 time unit after the rising edge.
   task automatic step(input logic d, input logic v);
      din     = d;
      din_vld = v;
      @(posedge clk);
      #1;
   endtask

   // Reference XNOR PRBS-15 generator.
   task automatic gen(output logic b);
      b = ~(g[14] ^ g[13]);
      g = {g[13:0], b};
   endtask

   task automatic clean(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step(b, 1'b1);
      end
   endtask

   task automatic bad(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step(~b, 1'b1);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1'b1, 1'b1);
      clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic b;
      rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
      g = 15'h0001;
      #12;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_lockup", 32'(lockup), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clean lock: 23rd valid bit raises locked
      clean(22);
      check("lock_22", 32'(locked), 32'd0);
      clean(1);
      check("lock_23", 32'(locked), 32'd1);
      check("sat_lock_23", 32'(s_locked), 32'd1);
      err_pulses = 0;
      for (int i = 0; i < 9977; i++) begin
         gen(b);
         step(b, 1'b1);
         if (err) err_pulses++;
      end
      check("clean_err_pulses", 32'(err_pulses), 32'd0);
      check("clean_err_cnt", 32'(err_cnt), 32'd0);
      check("clean_locked", 32'(locked), 32'd1);

      // Single flipped bit
      bad(1);
      check("single_err", 32'(err), 32'd1);
      check("single_err_cnt", 32'(err_cnt), 32'd1);
      check("single_locked", 32'(locked), 32'd1);
      clean(1);
      check("single_err_after", 32'(err), 32'd0);
      check("single_err_cnt_after", 32'(err_cnt), 32'd1);

      // Loss after 4 consecutive mismatches, then relock
      bad(3);
      check("loss_3_locked", 32'(locked), 32'd1);
      check("loss_3_err_cnt", 32'(err_cnt), 32'd4);
      bad(1);
      check("loss_4_locked", 32'(locked), 32'd0);
      check("loss_4_err", 32'(err), 32'd1);
      check("loss_4_err_cnt", 32'(err_cnt), 32'd5);
      clean(22);
      check("relock_22", 32'(locked), 32'd0);
      clean(1);
      check("relock_23", 32'(locked), 32'd1);
      check("relock_err_cnt", 32'(err_cnt), 32'd5);

      // Gapped input after clear
      do_clr();
      check("clr_locked", 32'(locked), 32'd0);
      check("clr_err_cnt", 32'(err_cnt), 32'd0);
      nv = 0; cyc = 0;
      while (nv < 30 && cyc < 1000) begin
         cyc++;
         if ($urandom_range(0, 1) == 1) begin
            gen(b);
            step(b, 1'b1);
            nv++;
         end else begin
            step(1'($urandom_range(0, 1)), 1'b0);
         end
         check("gap_locked", 32'(locked), 32'(nv >= 23));
         check("gap_err", 32'(err), 32'd0);
      end
      check("gap_valid_bits", 32'(nv), 32'd30);
      check("gap_err_cnt", 32'(err_cnt), 32'd0);

      // Lockup stream of constant ones
      do_clr();
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      check("lockup_14", 32'(lockup), 32'd0);
      step(1'b1, 1'b1);
      check("lockup_15", 32'(lockup), 32'd1);
      for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
      check("lockup_hold", 32'(lockup), 32'd1);
      check("lockup_locked", 32'(locked), 32'd0);
      check("lockup_err_cnt", 32'(err_cnt), 32'd0);

      // Saturation on the 4-bit instance, then clear with a valid bit
      do_clr();
      clean(23);
      check("sat_locked", 32'(s_locked), 32'd1);
      bad(14);
      check("sat_cnt_14", 32'(s_err_cnt), 32'd14);
      check("sat_locked_14", 32'(s_locked), 32'd1);
      bad(1);
      check("sat_cnt_15", 32'(s_err_cnt), 32'd15);
      bad(5);
      check("sat_cnt_hold", 32'(s_err_cnt), 32'd15);
      check("sat_err", 32'(s_err), 32'd1);
      check("sat_locked_20", 32'(s_locked), 32'd1);
      do_clr();
      check("sat_clr_cnt", 32'(s_err_cnt), 32'd0);
      check("sat_clr_locked", 32'(s_locked), 32'd0);
      check("sat_clr_lockup", 32'(s_lockup), 32'd0);
      clean(22);
      check("sat_reseed_22", 32'(s_locked), 32'd0);
      clean(1);
      check("sat_reseed_23", 32'(s_locked), 32'd1);
      check("main_reseed_23", 32'(locked), 32'd1);

      // Asynchronous reset while locked with an error pulse showing
      bad(1);
      check("pre_rst_err", 32'(err), 32'd1);
      check("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
      rst_n = 1'b0;
      #2;
      check("async_locked", 32'(locked), 32'd0);
      check("async_err", 32'(err), 32'd0);
      check("async_err_cnt", 32'(err_cnt), 32'd0);
      check("async_sat_locked", 32'(s_locked), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_xnor_prbs_chk.md
# m_xnor_prbs_chk

Receive-side checker for the XNOR-feedback PRBS-15 test stream (x^15 + x^14 + 1) used on on-chip serial links and the BIST paths. It accepts one bit per qualified cycle, self-synchronises to the incoming sequence, and declares lock. Once locked, it counts bit errors in a saturating counter. It is the far end of the PRBS generator and sits beside the link receiver, with its status exposed to the test/CSR block.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive correct predictions required to declare lock (1..255).
- LOSS_THR, 4: consecutive mismatches while locked that force resynchronisation (1..255).
- ERR_W, 16: width of the error counter.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clr, input, 1: synchronous clear; state returns to SEED and all counters and outputs clear. Has priority over din_vld.
- din_vld, input, 1: din is valid this cycle.
- din, input, 1: received PRBS bit.
- locked, output, 1: registered; high while in LOCKED.
- err, output, 1: registered one-cycle pulse per mismatched bit while LOCKED.
- err_cnt, output, ERR_W: registered saturating count of mismatches while LOCKED.
- lockup, output, 1: registered; high when the seeded shift register equals all-ones.

## Operation
Shift register and prediction:
- Shift register sr[14:0], with sr[0] the newest bit.
- Predicted bit p = ~(sr[14] ^ sr[13]) (XNOR). The all-ones state is the XNOR lockup state.
- A bit is consumed only when din_vld=1. With din_vld=0, all state holds and err=0.

States:
- **SEED**
  - Each valid bit: sr <= {sr[13:0], din}; seed_cnt++.
  - After the 15th bit: if the new sr is all-ones, set lockup=1, reset seed_cnt and stay in SEED. Otherwise set lockup=0 and go to VERIFY with match_cnt=0.
- **VERIFY**
  - Each valid bit: sr <= {sr[13:0], din}.
  - If din==p, match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED.
  - If din!=p, return to SEED with seed_cnt=0. No error is counted.
- **LOCKED**
  - Each valid bit: sr <= {sr[13:0], p}. The register advances on the prediction, so one flipped bit yields exactly one error.
  - If din!=p: err=1, err_cnt++ (saturates at 2^ERR_W−1), miss_cnt++.
  - If din==p: miss_cnt=0.
  - When miss_cnt reaches LOSS_THR, go to SEED with seed_cnt=0. locked drops; err_cnt is retained.

Other rules:
- clr and a valid bit in the same cycle: clr wins and the bit is discarded.
- Reset values: state SEED, sr=0, all counters 0, locked=0, err=0, err_cnt=0, lockup=0.
- Reset mid-operation clears everything immediately (asynchronous); the reset release is synchronised externally.

## Timing
- All outputs are registered and change on the edge that samples the causing bit.
- err is high for the cycle following the mismatching sample.
- locked goes high in the cycle after the (15+LOCK_CNT)-th valid bit from SEED entry, given a clean stream.
- locked goes low in the cycle after the LOSS_THR-th consecutive mismatch.
- err_cnt updates on the same edge as err rises.
- Throughput is one bit per cycle, with no bubbles required.
- din_vld gaps of any length are transparent: only valid bits count toward seed, lock and loss thresholds.

## Test plan
1. **Clean lock:** generator seeded 15'h0001, din_vld=1 continuously → locked=1 in the cycle after the 23rd bit; err_cnt stays 0 over 10,000 bits.
2. **Single error:** after lock, invert one bit → exactly one err pulse; err_cnt=1; locked stays 1.
3. **Gapped input:** clean stream with din_vld toggling pseudo-randomly at about 50% → lock after 23 valid bits; no errors; outputs hold during gaps.
4. **Loss and relock:** after lock, invert 4 consecutive bits → err_cnt=4; locked falls after the 4th; locked returns 23 valid bits later; err_cnt remains 4.
5. **Lockup stream:** constant din=1 → lockup=1 after 15 bits; locked never rises; err_cnt=0.
6. **Saturation and clear:** ERR_W=4 with a random-data stream while forced LOCKED (LOSS_THR=255) → err_cnt saturates at 15. Then assert clr with din_vld=1 → next cycle err_cnt=0, locked=0, state SEED.
7. **Reset mid-lock:** assert rst_n=0 while locked → locked, err and err_cnt go to 0 immediately.
